addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

- Shares the single saturating 16-bit add/sub unit between `N_REQ` requesters (e.g. ALU, branch-target adder, address-offset generator) using round-robin arbitration.
- Each request is captured, executed for one cycle, and held as a tagged response until consumed.
- Produces the saturated result plus Z/N flags; sits between the decode-side requesters and the writeback/flag logic.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `ID_W`, default 2: width of the requester tag, `$clog2(N_REQ)`, minimum 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_sub` in `N_REQ`: per-requester operation (1 = A−B, 0 = A+B).
- `req_a` in `16*N_REQ`: packed A operands; requester i is at `[16i+15:16i]`.
- `req_b` in `16*N_REQ`: packed B operands, same packing.
- `req_ready` out `N_REQ`: one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `resp_valid` out 1: response held valid.
- `resp_ready` in 1: consumer accepts the response.
- `resp_id` out `ID_W`: index of the requester that owns the response.
- `resp_sum` out 16: saturated result.
- `resp_z` out 1: `resp_sum == 0`.
- `resp_n` out 1: `resp_sum[15]`.
- `busy` out 1: state is not IDLE.

## Operation
- **States**
  - IDLE, EXEC, RESP; reset state is IDLE.
- **IDLE**
  - If any `req_valid` is set, assert `req_ready` for the round-robin winner only.
  - On the edge: capture the winner's a, b, sub and id into operand registers; go to EXEC.
  - With no requests, stay in IDLE and keep `req_ready` = 0.
- **EXEC**
  - Operand registers drive the shared unit combinationally.
  - On the edge: capture sum, z, n and id into the response registers; go to RESP.
  - `req_ready` = 0.
- **RESP**
  - `resp_valid` = 1.
  - Without `resp_ready`: hold every `resp_*` output stable; `req_ready` = 0.
  - With `resp_ready` and any `req_valid`: grant the winner in the same cycle, capture its operands, go to EXEC (back-to-back).
  - With `resp_ready` and no request: go to IDLE.
- **Round-robin**
  - A pointer `rr_ptr` is reset to 0.
  - Search order is `rr_ptr, rr_ptr+1, …` modulo `N_REQ`.
  - After a grant to index k, `rr_ptr` becomes `(k+1) mod N_REQ`, wrapping from `N_REQ-1` to 0.
  - The pointer is unchanged when no grant occurs.
- **Arithmetic**
  - Two's complement. Positive overflow saturates to 16'h7FFF; negative overflow saturates to 16'h8000.
  - Subtraction is A + ~B + 1, with saturation evaluated on the complemented B.
  - Flags are computed from the saturated result.
- **Requester rules**
  - A requester holds `req_valid` and its operands stable until granted.
  - A dropped `req_valid` is simply not granted; it is not an error.
- **Reset mid-operation**
  - Any in-flight operation or held response is discarded.
  - All outputs go to 0 immediately; state returns to IDLE and `rr_ptr` to 0.

## Timing
- Reset values: `req_ready` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_sum` = 16'h0000, `resp_z` = 0, `resp_n` = 0, `busy` = 0.
- `req_ready` is combinational from `req_valid`, state, `rr_ptr` and `resp_ready`.
- `resp_*` outputs come straight from registers.
- Latency: grant in cycle t gives `resp_valid` high in cycle t+2.
- Throughput: one operation per 2 cycles with `resp_ready` held high.
- No combinational path from `req_a`/`req_b` to any output.

## Structure
- Shared package holds:
  - the state encoding `arb_state_t` (IDLE=2'b00, EXEC=2'b01, RESP=2'b10);
  - `SAT_POS` = 16'h7FFF and `SAT_NEG` = 16'h8000.
- One sub-module: `addsub_16bit`, the existing saturating adder/subtractor. It is instantiated once and fed from the operand registers.
- The round-robin winner select is a function or always block inside this module, not a separate module.

## Test plan
- **Single add:** req0 with a=16'h0003, b=16'h0004, sub=0 → `req_ready` = 3'b001 that cycle; two cycles later `resp_valid` = 1, sum=16'h0007, id=0, z=0, n=0.
- **Saturation:** req1 with 16'h7FFF+16'h0001 → sum=16'h7FFF, n=0. req1 with 16'h8000 − 16'h0001 → sum=16'h8000, n=1. 16'h1234 − 16'h1234 → sum=16'h0000, z=1.
- **Fairness:** all three requesters valid continuously with `resp_ready` = 1 → grant order 0,1,2,0,1,2. A new grant is issued in every RESP cycle (back-to-back). `resp_id` follows the same order.
- **Back-pressure:** `resp_ready` = 0 for 5 cycles in RESP → `resp_*` outputs unchanged, `req_ready` = 0. Raising `resp_ready` while req2 is valid → req2 is granted that cycle.
- **Wrap-around:** with `N_REQ` = 3 and `rr_ptr` = 2, only req0 and req2 valid → req2 granted first, then req0.
- **Reset mid-operation:** drop `rst_n` during EXEC → outputs are 0 asynchronously. After release, the first request from req1 (pointer 0, req0 idle) is granted and completes normally.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// rtl/addsub_arbiter_pkg.sv - state encoding and saturation limits for the add/sub arbiter
package addsub_arbiter_pkg;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - request/response bundle between requesters and the add/sub arbiter
interface addsub_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_sub;
    logic [16*N_REQ-1:0] req_a;
    logic [16*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;

    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [15:0]         resp_sum;
    logic                resp_z;
    logic                resp_n;

    // requesters plus the writeback consumer
    modport master (
        output req_valid, req_sub, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_sum, resp_z, resp_n
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_sum, resp_z, resp_n
    );

endinterface

// File: rtl/addsub_16bit.sv
// rtl/addsub_16bit.sv - saturating 16-bit two's complement adder/subtractor with Z/N flags
module addsub_16bit
    import addsub_arbiter_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        z,
    output logic        n
);

    logic [15:0] b_eff;
    logic [15:0] raw;
    logic        ovf;

    assign b_eff = sub ? ~b : b;
    assign raw   = a + b_eff + {15'b0, sub};

    // overflow judged against the complemented operand, so A - 16'h8000 saturates correctly
    assign ovf = (a[15] == b_eff[15]) && (raw[15] != a[15]);

    assign sum = ovf ? (a[15] ? SAT_NEG : SAT_POS) : raw;
    assign z   = (sum == 16'h0000);
    assign n   = sum[15];

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin sharing of one saturating add/sub unit between N_REQ requesters
module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    addsub_arbiter_if.slave bus,
    output logic            busy
);

    arb_state_t      state;
    arb_state_t      state_next;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic            grant_en;
    logic            grant_fire;

    logic [15:0]     sel_a;
    logic [15:0]     sel_b;
    logic            sel_sub;

    logic [15:0]     op_a;
    logic [15:0]     op_b;
    logic            op_sub;
    logic [ID_W-1:0] op_id;

    logic [15:0]     alu_sum;
    logic            alu_z;
    logic            alu_n;

    logic            resp_valid_q;
    logic [ID_W-1:0] resp_id_q;
    logic [15:0]     resp_sum_q;
    logic            resp_z_q;
    logic            resp_n_q;

    // Winner: lowest valid index at or above rr_ptr; failing that, lowest valid index below it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (ID_W'(i) < rr_ptr)) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                win_found = 1'b1;
                win_idx   = ID_W'(i);
            end
        end
    end

    assign ptr_next   = (win_idx == ID_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign grant_en   = rst_n && ((state == IDLE) || ((state == RESP) && bus.resp_ready));
    assign grant_fire = grant_en && win_found;

    always_comb begin
        bus.req_ready = '0;
        sel_a         = '0;
        sel_b         = '0;
        sel_sub       = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                bus.req_ready[i] = grant_fire;
                sel_a            = bus.req_a[16*i +: 16];
                sel_b            = bus.req_b[16*i +: 16];
                sel_sub          = bus.req_sub[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_fire) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.resp_ready) state_next = grant_fire ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    addsub_16bit u_addsub (
        .a   (op_a),
        .b   (op_b),
        .sub (op_sub),
        .sum (alu_sum),
        .z   (alu_z),
        .n   (alu_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            op_a         <= '0;
            op_b         <= '0;
            op_sub       <= 1'b0;
            op_id        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_z_q     <= 1'b0;
            resp_n_q     <= 1'b0;
        end else begin
            if (grant_fire) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_sub <= sel_sub;
                op_id  <= win_idx;
                rr_ptr <= ptr_next;
            end
            if (state == EXEC) begin
                resp_valid_q <= 1'b1;
                resp_id_q    <= op_id;
                resp_sum_q   <= alu_sum;
                resp_z_q     <= alu_z;
                resp_n_q     <= alu_n;
            end else if ((state == RESP) && bus.resp_ready) begin
                resp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_sum   = resp_sum_q;
    assign bus.resp_z     = resp_z_q;
    assign bus.resp_n     = resp_n_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - scoreboard bench for addsub_arbiter with directed vectors
module tb_addsub_arbiter;

    localparam int N_REQ = 3;
    localparam int ID_W  = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     sum;
        logic            z;
        logic            n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    addsub_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    addsub_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT event did not occur within the cycle budget", name);
    endtask

    task automatic push_exp(input int id, input logic [15:0] s, input logic z, input logic n);
        exp_t e;
        e.id  = ID_W'(id);
        e.sum = s;
        e.z   = z;
        e.n   = n;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b, input logic sub);
        bus.req_a[16*idx +: 16] = a;
        bus.req_b[16*idx +: 16] = b;
        bus.req_sub[idx]        = sub;
        bus.req_valid[idx]      = 1'b1;
    endtask

    // Raise one request, wait for its grant, optionally register the expected response.
    task automatic issue(input int idx, input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic [15:0] s, input logic z, input logic n, input bit push);
        int waited = 0;
        @(negedge clk);
        set_req(idx, a, b, sub);
        #1;
        while (bus.req_ready == '0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.req_ready == '0) begin
            timeout("grant_wait");
        end else begin
            check("grant_onehot", 32'(bus.req_ready), 32'(1) << idx);
            if (push) push_exp(idx, s, z, n);
        end
        @(posedge clk);
        #1;
        bus.req_valid[idx] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int waited = 0;
        @(negedge clk);
        #1;
        while (busy && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (busy) timeout(name);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("resp_unexpected", 32'(exp_q.size()), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id",  32'(bus.resp_id),  32'(e.id));
                    check("resp_sum", 32'(bus.resp_sum), 32'(e.sum));
                    check("resp_z",   32'(bus.resp_z),   32'(e.z));
                    check("resp_n",   32'(bus.resp_n),   32'(e.n));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cyc;
        int grants;
        int last;
        int waited;

        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_sub    = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready",  32'(bus.req_ready),  32'h0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("rst_resp_id",    32'(bus.resp_id),    32'h0);
        check("rst_resp_sum",   32'(bus.resp_sum),   32'h0);
        check("rst_resp_z",     32'(bus.resp_z),     32'h0);
        check("rst_resp_n",     32'(bus.resp_n),     32'h0);
        check("rst_busy",       32'(busy),           32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // single add and two-cycle latency
        issue(0, 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        check("lat_exec_valid", 32'(bus.resp_valid), 32'h0);
        check("lat_exec_busy",  32'(busy),           32'h1);
        @(negedge clk);
        #1;
        check("lat_resp_valid", 32'(bus.resp_valid), 32'h1);

        // saturation and flags
        issue(1, 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        issue(1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1);
        issue(1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        issue(2, 16'h8000, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        issue(0, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        issue(1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b1);
        issue(2, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b1);

        // fairness: all requesters continuously valid, pointer back at 0
        wait_idle("idle_before_fair");
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) set_req(i, 16'(i + 1), 16'h0010, 1'b0);
        cyc    = 0;
        grants = 0;
        last   = 0;
        while (grants < 6 && cyc < 40) begin
            #1;
            if (bus.req_ready != '0) begin
                check("fair_grant", 32'(bus.req_ready), 32'(1) << (grants % 3));
                if (grants > 0) check("fair_b2b_gap", 32'(cyc - last), 32'h2);
                last = cyc;
                push_exp(grants % 3, 16'(16'h0011 + grants % 3), 1'b0, 1'b0);
                grants++;
            end
            if (grants < 6) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (grants < 6) timeout("fair_grants");
        @(posedge clk);
        #1;
        bus.req_valid = '0;

        // back-pressure: response held for five cycles, req2 waits
        wait_idle("idle_before_bp");
        bus.resp_ready = 1'b0;
        issue(0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        set_req(2, 16'h0005, 16'h0003, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check("bp_resp_valid", 32'(bus.resp_valid), 32'h1);
            check("bp_resp_sum",   32'(bus.resp_sum),   32'h3333);
            check("bp_resp_id",    32'(bus.resp_id),    32'h0);
            check("bp_req_ready",  32'(bus.req_ready),  32'h0);
        end
        bus.resp_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(bus.req_ready), 32'h4);
        push_exp(2, 16'h0002, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;

        // wrap-around: move pointer to 2, then req0 and req2 together
        wait_idle("idle_before_wrap");
        issue(1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b0, 1'b0, 1'b1);
        wait_idle("idle_wrap");
        @(negedge clk);
        set_req(0, 16'h0002, 16'h0002, 1'b0);
        set_req(2, 16'h7000, 16'h7000, 1'b0);
        #1;
        check("wrap_first", 32'(bus.req_ready), 32'h4);
        push_exp(2, 16'h7FFF, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.req_valid[2] = 1'b0;
        waited = 0;
        @(negedge clk);
        #1;
        while (bus.req_ready == '0 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (bus.req_ready == '0) begin
            timeout("wrap_second_wait");
        end else begin
            check("wrap_second", 32'(bus.req_ready), 32'h1);
            push_exp(0, 16'h0004, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        bus.req_valid[0] = 1'b0;

        // reset while EXEC; the in-flight op must vanish
        wait_idle("idle_before_reset");
        issue(0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready",  32'(bus.req_ready),  32'h0);
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        check("mid_rst_resp_id",    32'(bus.resp_id),    32'h0);
        check("mid_rst_resp_sum",   32'(bus.resp_sum),   32'h0);
        check("mid_rst_resp_z",     32'(bus.resp_z),     32'h0);
        check("mid_rst_resp_n",     32'(bus.resp_n),     32'h0);
        check("mid_rst_busy",       32'(busy),           32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, 16'h0002, 16'hFFFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        wait_idle("idle_at_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
